// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed seven-segment display scanner
// Define SEG_HEX_EN to decode nibbles 10-15 as A,b,C,d,E,F; otherwise they show blank.
module seven_segment_scanner #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   disp_q;
    logic [N_DIGITS-1:0]     dp_reg_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    last_idx;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [N_DIGITS-1:0]     blank_vec;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
`ifdef SEG_HEX_EN
            4'd10:   decode = 7'b1110111;
            4'd11:   decode = 7'b0011111;
            4'd12:   decode = 7'b1001110;
            4'd13:   decode = 7'b0111101;
            4'd14:   decode = 7'b1001111;
            4'd15:   decode = 7'b1000111;
`endif
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign tick     = enable && (presc_q == PW'(REFRESH_DIV - 1));
    assign last_idx = (idx_q == IW'(N_DIGITS - 1));
    assign presc_d  = tick ? '0 : presc_q + 1'b1;
    assign idx_d    = last_idx ? '0 : idx_q + 1'b1;

    // A digit is blanked when it and every more significant nibble are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (disp_q[4*i +: 4] == 4'd0);
            blank_vec[i] = blank_lz && zero_above && (i > 0);
        end
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        dp_d      = 1'b0;
        an_d      = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_blank = blank_vec[i];
                dp_d      = dp_reg_q[i];
                an_d[i]   = 1'b1;
            end
        end
        seg_d        = cur_blank ? 7'b0000000 : decode(cur_nib);
        frame_done_d = tick && last_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            dp_reg_q     <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (load) begin
                disp_q   <= value;
                dp_reg_q <= dp_in;
            end
            if (enable) begin
                presc_q      <= presc_d;
                if (tick) begin
                    idx_q <= idx_d;
                end
                seg_q        <= seg_d;
                dp_q         <= dp_d;
                an_q         <= an_d;
                frame_done_q <= frame_done_d;
            end else begin
                seg_q        <= '0;
                dp_q         <= 1'b0;
                an_q         <= '0;
                frame_done_q <= 1'b0;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for seven_segment_scanner (N_DIGITS=4, REFRESH_DIV=4)
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seven_segment_scanner #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_presc;
    int          m_idx;
    logic [15:0] m_disp;
    logic [3:0]  m_dpr;

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011,
`ifdef SEG_HEX_EN
              7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`else
              7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
`endif
        return t[n];
    endfunction

    // Predict this edge's outputs from the pre-edge model state, advance the model, then clock the DUT.
    task automatic cycle();
        exp_t e;
        logic [15:0] sh;
        e = '0;
        if (!rst_n) begin
            m_presc = 0;
            m_idx   = 0;
            m_disp  = '0;
            m_dpr   = '0;
        end else begin
            if (enable) begin
                sh       = m_disp >> (4 * m_idx);
                e.an     = 4'(1 << m_idx);
                e.seg    = (blank_lz && m_idx > 0 && sh == 16'h0) ? 7'b0 : ref_glyph(sh[3:0]);
                e.dp     = m_dpr[m_idx];
                e.fd     = (m_presc == 3) && (m_idx == 3);
                if (m_presc == 3) begin
                    m_presc = 0;
                    m_idx   = (m_idx + 1) % 4;
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            if (load) begin
                m_disp = value;
                m_dpr  = dp_in;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; enable = 1'b1; load = 1'b1; value = 16'h5A5A; dp_in = 4'hF; blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++;
            if ({an, seg, dp, frame_done} !== e) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got an=%b seg=%b dp=%b fd=%b, want %b", i, an, seg, dp, frame_done, e);
            end
        end
        n_checks++;
        if ({an, seg, dp, frame_done} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_zero: got %b want 0", {an, seg, dp, frame_done});
        end
        load = 1'b0; rst_n = 1'b1;
        cycle();
        e = sb.pop_front();
        n_checks++;
        if (an !== 4'b0001 || seg !== 7'b1111110 || dp !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got an=%b seg=%b dp=%b want an=0001 seg=1111110 dp=0", an, seg, dp);
        end
    endtask

    task automatic test_basic_scan();
        exp_t e;
        int   fd_cnt;
        load = 1'b1; value = 16'h1234; dp_in = 4'b0000;
        cycle(); void'(sb.pop_front());
        load = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++;
            if ({an, seg, dp, frame_done} !== e) begin
                n_fail++;
                $display("FAIL scan cyc%0d: got an=%b seg=%b dp=%b fd=%b, want %b", i, an, seg, dp, frame_done, e);
            end
            if (i >= 8) fd_cnt += int'(frame_done);
            if (an == 4'b0001) begin
                n_checks++;
                if (seg !== 7'b0110011) begin
                    n_fail++;
                    $display("FAIL scan_digit0: got %b want 0110011", seg);
                end
            end
            if (an == 4'b1000) begin
                n_checks++;
                if (seg !== 7'b0110000) begin
                    n_fail++;
                    $display("FAIL scan_digit3: got %b want 0110000", seg);
                end
            end
        end
        n_checks++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d want 2 in 32 cycles", fd_cnt);
        end
    endtask

    task automatic test_blanking();
        exp_t e;
        load = 1'b1; value = 16'h0070; blank_lz = 1'b1;
        cycle(); void'(sb.pop_front());
        load = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            blank_lz = (pass == 0);
            for (int i = 0; i < 20; i++) begin
                cycle();
                e = sb.pop_front();
                n_checks++;
                if ({an, seg, dp, frame_done} !== e) begin
                    n_fail++;
                    $display("FAIL blank p%0d cyc%0d: got an=%b seg=%b, want %b", pass, i, an, seg, e);
                end
                if (an == 4'b1000 || an == 4'b0100) begin
                    n_checks++;
                    if (seg !== (pass == 0 ? 7'b0000000 : 7'b1111110)) begin
                        n_fail++;
                        $display("FAIL blank_hi p%0d: an=%b got seg=%b", pass, an, seg);
                    end
                end
                if (an == 4'b0010) begin
                    n_checks++;
                    if (seg !== 7'b1110000) begin
                        n_fail++;
                        $display("FAIL blank_d1 p%0d: got %b want 1110000", pass, seg);
                    end
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_hex();
        exp_t       e;
        logic [6:0] want1, want0;
`ifdef SEG_HEX_EN
        want1 = 7'b1110111; want0 = 7'b1000111;
`else
        want1 = 7'b0000000; want0 = 7'b0000000;
`endif
        load = 1'b1; value = 16'h00AF;
        cycle(); void'(sb.pop_front());
        load = 1'b0;
        for (int i = 0; i < 18; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++;
            if ({an, seg, dp, frame_done} !== e) begin
                n_fail++;
                $display("FAIL hex cyc%0d: got an=%b seg=%b, want %b", i, an, seg, e);
            end
            if (i >= 2 && (an == 4'b0010 || an == 4'b0001)) begin
                n_checks++;
                if (seg !== (an == 4'b0010 ? want1 : want0)) begin
                    n_fail++;
                    $display("FAIL hex_glyph an=%b: got %b want %b", an, seg, (an == 4'b0010 ? want1 : want0));
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        exp_t e;
        for (int i = 0; i < 8 && m_presc != 1; i++) begin
            cycle(); void'(sb.pop_front());
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++;
            if ({an, seg, dp, frame_done} !== 13'b0 || e !== 13'b0) begin
                n_fail++;
                $display("FAIL freeze cyc%0d: got %b want 0", i, {an, seg, dp, frame_done});
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++;
            if ({an, seg, dp, frame_done} !== e) begin
                n_fail++;
                $display("FAIL resume cyc%0d: got an=%b seg=%b fd=%b, want %b", i, an, seg, frame_done, e);
            end
        end
    endtask

    task automatic test_load_on_tick();
        exp_t e;
        for (int i = 0; i < 8 && m_presc != 3; i++) begin
            cycle(); void'(sb.pop_front());
        end
        load = 1'b1; value = 16'h9999; dp_in = 4'b0100;
        cycle(); void'(sb.pop_front());
        load = 1'b0; dp_in = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            cycle();
            e = sb.pop_front();
            n_checks++;
            if ({an, seg, dp, frame_done} !== e) begin
                n_fail++;
                $display("FAIL tickload cyc%0d: got an=%b seg=%b dp=%b, want %b", i, an, seg, dp, e);
            end
            n_checks++;
            if (seg !== 7'b1111011 || dp !== (an == 4'b0100)) begin
                n_fail++;
                $display("FAIL tickload_glyph cyc%0d: an=%b got seg=%b dp=%b want seg=1111011", i, an, seg, dp);
            end
        end
    endtask

    task automatic test_reset_midframe();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            cycle(); void'(sb.pop_front());
        end
        rst_n = 1'b0; load = 1'b1; value = 16'h8888;
        cycle();
        e = sb.pop_front();
        n_checks++;
        if ({an, seg, dp, frame_done} !== 13'b0 || e !== 13'b0) begin
            n_fail++;
            $display("FAIL midreset: got %b want 0", {an, seg, dp, frame_done});
        end
        rst_n = 1'b1; load = 1'b0;
        cycle();
        e = sb.pop_front();
        n_checks++;
        if (an !== 4'b0001 || seg !== 7'b1111110 || {an, seg, dp, frame_done} !== e) begin
            n_fail++;
            $display("FAIL midreset_release: got an=%b seg=%b want an=0001 seg=1111110", an, seg);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 200; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 5) == 0);
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_lz = 1'($urandom);
            if ($urandom_range(0, 7) == 0) value = value & 16'h00F0;
            cycle();
            e = sb.pop_front();
            n_checks++;
            if ({an, seg, dp, frame_done} !== e) begin
                n_fail++;
                $display("FAIL random cyc%0d: got an=%b seg=%b dp=%b fd=%b, want %b", i, an, seg, dp, frame_done, e);
            end
        end
        enable = 1'b1; load = 1'b0;
    endtask

    initial begin
        m_presc = 0; m_idx = 0; m_disp = '0; m_dpr = '0;
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        test_reset();
        test_basic_scan();
        test_blanking();
        test_hex();
        test_enable_freeze();
        test_load_on_tick();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
